sort_drain: RTL and testbench



---
 rtl/sort_pkg.sv | 37 +++
 rtl/sort_drain.sv | 94 +++++++++
 tb/tb_sort_drain.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the insertion sorter and its drain stage.
// No logic; state codes, defaults and a state-name helper for tracing.
// Not applicable: no flow control lives here.
package sort_pkg;

    localparam int DW_DEF = 16;
    localparam int AW_DEF = 4;

    // Sorter state codes, kept here so both stages share one encoding space.
    localparam logic [2:0] SORT_IDLE  = 3'd0;
    localparam logic [2:0] SORT_LOAD  = 3'd1;
    localparam logic [2:0] SORT_SCAN  = 3'd2;
    localparam logic [2:0] SORT_SHIFT = 3'd3;
    localparam logic [2:0] SORT_DONE  = 3'd4;

    localparam logic [2:0] D_IDLE    = 3'd0;
    localparam logic [2:0] D_FETCH   = 3'd1;
    localparam logic [2:0] D_CAPT    = 3'd2;
    localparam logic [2:0] D_PRESENT = 3'd3;
    localparam logic [2:0] D_DONE    = 3'd4;

    // Five-character ASCII name of a drain state, for console tracing.
    function automatic logic [39:0] drain_state_name(input logic [2:0] s);
        logic [39:0] name;
        name = "?????";
        case (s)
            D_IDLE:    name = "IDLE ";
            D_FETCH:   name = "FETCH";
            D_CAPT:    name = "CAPT ";
            D_PRESENT: name = "PRES ";
            D_DONE:    name = "DONE ";
            default:   name = "?????";
        endcase
        return name;
    endfunction

endpackage

// File: rtl/sort_drain.sv
// Streams the zero-terminated sorted RAM image out, checking ascending order.
// Latency: first out_valid two cycles after start is taken; 3 cycles/element.
// Backpressure: holds out_valid/out_data in PRESENT until out_ready; no RAM write until then.
module sort_drain
    import sort_pkg::*;
#(
    parameter int DW               = DW_DEF,
    parameter int AW               = AW_DEF,
    parameter bit CLEAR_AFTER_READ = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_rdata,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   count,
    output logic          order_err
);

    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

    logic [2:0]    state;
    logic [DW-1:0] prev;
    logic          hs;

    assign hs = (state == D_PRESENT) && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= D_IDLE;
            ram_addr  <= '0;
            out_data  <= '0;
            count     <= '0;
            order_err <= 1'b0;
            prev      <= '0;
        end else begin
            case (state)
                D_IDLE: begin
                    if (start) begin
                        state     <= D_FETCH;
                        ram_addr  <= '0;
                        count     <= '0;
                        order_err <= 1'b0;
                        prev      <= '0;
                    end
                end
                D_FETCH: state <= D_CAPT;
                D_CAPT: begin
                    if (ram_rdata == '0) begin
                        state <= D_DONE;
                    end else begin
                        out_data <= ram_rdata;
                        // The first element has no predecessor to compare with.
                        if (count != '0 && ram_rdata < prev)
                            order_err <= 1'b1;
                        state <= D_PRESENT;
                    end
                end
                D_PRESENT: begin
                    if (out_ready) begin
                        count <= count + 1'b1;
                        prev  <= out_data;
                        // Checking the last address first keeps ram_addr from wrapping.
                        if (ram_addr == LAST_ADDR) begin
                            state <= D_DONE;
                        end else begin
                            ram_addr <= ram_addr + 1'b1;
                            state    <= D_FETCH;
                        end
                    end
                end
                D_DONE: begin
                    if (!start)
                        state <= D_IDLE;
                end
                default: state <= D_IDLE;
            endcase
        end
    end

    assign out_valid = (state == D_PRESENT);
    assign ram_we    = hs && CLEAR_AFTER_READ;
    assign ram_wdata = '0;
    assign busy      = (state == D_FETCH) || (state == D_CAPT) || (state == D_PRESENT);
    assign done      = (state == D_DONE);

endmodule

// File: tb/tb_sort_drain.sv
// Randomized bench for sort_drain: a RAM model feeds it and a queue-based
// reference predicts stream, count, order flag, write-backs and timing.
module tb_sort_drain;
    import sort_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_rdata;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
    logic          order_err;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] load_img [DEPTH];
    logic          load_req;

    int total = 0;
    int bad   = 0;

    sort_drain #(.DW(DW), .AW(AW), .CLEAR_AFTER_READ(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .ram_addr(ram_addr), .ram_rdata(ram_rdata), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .count(count), .order_err(order_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_req) begin
            mem <= load_img;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load_mem();
        @(negedge clk) load_req = 1'b1;
        @(negedge clk) load_req = 1'b0;
    endtask

    // One full drain from IDLE; rdy_pct is the chance of out_ready per cycle,
    // stall_on names a value whose handshake is held off for five cycles.
    task automatic drain(input int rdy_pct, input bit timing_chk, input logic [DW-1:0] stall_on);
        logic [DW-1:0] snap [DEPTH];
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] got_q [$];
        logic [DW-1:0] stall_dat;
        logic [AW:0]   stall_cnt;
        bit            exp_oe;
        bit            stall;
        int            we_cnt, first_vld, done_at, held, n;

        snap = mem;
        exp_oe = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (snap[i] == '0) break;
            if (exp_q.size() > 0 && snap[i] < exp_q[$]) exp_oe = 1'b1;
            exp_q.push_back(snap[i]);
        end
        n = exp_q.size();
        we_cnt = 0; first_vld = 0; done_at = 0; held = 0; stall = 1'b0;
        stall_dat = '0; stall_cnt = '0;

        @(negedge clk) start = 1'b1;
        for (int i = 1; i <= 400 && done_at == 0; i++) begin
            @(negedge clk);
            #1;
            if (stall_on != '0 && out_valid && out_data == stall_on && held < 5) begin
                out_ready = 1'b0;
                held++;
            end else begin
                out_ready = ($urandom_range(0, 99) < rdy_pct);
            end
            #1;
            if (stall) begin
                chk("hold_vld", out_valid, 1);
                chk("hold_dat", out_data, stall_dat);
                chk("hold_cnt", count, stall_cnt);
            end
            if (out_valid && first_vld == 0) first_vld = i;
            if (ram_we) begin
                we_cnt++;
                chk("we_only_on_hs", out_valid && out_ready, 1);
            end
            if (out_valid && out_ready) got_q.push_back(out_data);
            stall     = out_valid && !out_ready;
            stall_dat = out_data;
            stall_cnt = count;
            if (done) done_at = i;
        end
        if (done_at == 0) chk("drain_timeout", 0, 1);
        $display("drain of %0d elements ends in %s", n, drain_state_name(dut.state));

        chk("n_out", got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) chk("data", got_q[i], exp_q[i]);
        chk("count", count, n);
        chk("order_err", order_err, exp_oe);
        chk("we_pulses", we_cnt, n);
        chk("done_busy", busy, 0);
        chk("done_vld", out_valid, 0);
        if (stall_on != '0) chk("stall_seen", held, 5);
        if (timing_chk) begin
            chk("first_vld_cycle", first_vld, (n > 0) ? 3 : 0);
            chk("done_cycle", done_at, (n == DEPTH) ? 3 * n + 1 : 3 * n + 3);
        end
        for (int i = 0; i < DEPTH; i++) chk("mem_after", mem[i], (i < n) ? '0 : snap[i]);

        repeat (2) @(negedge clk);
        #1;
        chk("done_held", done, 1);
        start = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_count_kept", count, n);
    endtask

    initial begin
        int len;
        logic [DW-1:0] v;

        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; load_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            load_img[i] = '0;
        end
        repeat (2) @(negedge clk);
        #1;
        chk("rst_addr", ram_addr, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_vld", out_valid, 0);
        chk("rst_dat", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_oerr", order_err, 0);
        rst_n = 1'b1;

        // Sorted with a duplicate, full-speed.
        load_img = '{default: '0};
        load_img[0] = 3; load_img[1] = 7; load_img[2] = 7; load_img[3] = 12;
        load_mem();
        drain(100, 1'b1, '0);

        // Out of order.
        load_img = '{default: '0};
        load_img[0] = 5; load_img[1] = 2; load_img[2] = 9;
        load_mem();
        drain(100, 1'b1, '0);

        // Full RAM, no terminator.
        for (int i = 0; i < DEPTH; i++) load_img[i] = DW'(i + 1);
        load_mem();
        drain(100, 1'b1, '0);

        // Backpressure on element 7.
        for (int i = 0; i < DEPTH; i++) load_img[i] = (i < 10) ? DW'(i + 1) : '0;
        load_mem();
        drain(100, 1'b0, 16'd7);

        // Empty RAM.
        load_img = '{default: '0};
        load_mem();
        drain(100, 1'b1, '0);

        // Reset while the second element is presented.
        load_img = '{default: '0};
        load_img[0] = 10; load_img[1] = 20; load_img[2] = 30;
        load_mem();
        @(negedge clk) start = 1'b1; out_ready = 1'b1;
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 50 && !hit; i++) begin
                @(negedge clk);
                #1;
                if (out_valid && count == 1) hit = 1'b1;
            end
            if (!hit) chk("reach_2nd_present", 0, 1);
        end
        out_ready = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("mid_rst_vld", out_valid, 0);
        chk("mid_rst_dat", out_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_oerr", order_err, 0);
        chk("mid_rst_addr", ram_addr, 0);
        chk("mid_rst_we", ram_we, 0);
        chk("mid_rst_mem0", mem[0], 0);
        chk("mid_rst_mem1", mem[1], 20);
        chk("mid_rst_mem2", mem[2], 30);
        drain(100, 1'b1, '0);
        load_img = '{default: '0};
        load_img[0] = 10; load_img[1] = 20; load_img[2] = 30;
        load_mem();
        drain(100, 1'b1, '0);

        // Random images: sorted or shuffled, random length, random readiness.
        for (int t = 0; t < 25; t++) begin
            len = $urandom_range(0, DEPTH);
            v = DW'($urandom_range(1, 50));
            for (int i = 0; i < DEPTH; i++) begin
                if (i >= len) begin
                    load_img[i] = '0;
                end else if (t % 2 == 0) begin
                    load_img[i] = v;
                    v = v + DW'($urandom_range(0, 3));
                end else begin
                    load_img[i] = DW'($urandom_range(1, 65535));
                end
            end
            load_mem();
            drain($urandom_range(30, 100), 1'b0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
